hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage ARM core (F/D/E/M/W).
//  - Drives the Exec-stage forwarding selects.
//  - Drives the stall and flush controls for F/D/E/M.
//  - Keeps a shadow tag pipeline (D->E->M->W) of destination-register and PC-write state.
//  - Sequences multi-cycle multiplies that hold the E stage for MUL_LAT cycles.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hz_fwd_sel.sv | 24 ++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// per-stage shadow tags and the tag match helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] wa3;
        logic       regw;
        logic       memtoreg;
        logic       pcs;
        logic [3:0] ra1;
        logic [3:0] ra2;
    } stage_tag_t;

    localparam stage_tag_t BUBBLE = '0;

    // r15 reads come from the PC path, never from a producer stage
    function automatic logic tag_hit(stage_tag_t t, logic [3:0] ra);
        return t.valid & t.regw & (t.wa3 == ra) & (ra != 4'd15);
    endfunction

endpackage

// File: rtl/hz_fwd_sel.sv
// Exec-stage operand forwarding select for one source port.
// The M stage holds the younger result, so it wins over W.
module hz_fwd_sel
    import hazard_pkg::*;
(
    input  logic [3:0] rax_e,
    input  stage_tag_t tag_m,
    input  stage_tag_t tag_w,
    output fwd_sel_t   sel
);

    logic unused_tag;
    assign unused_tag = ^{tag_m.memtoreg, tag_m.pcs, tag_m.ra1, tag_m.ra2,
                          tag_w.memtoreg, tag_w.pcs, tag_w.ra1, tag_w.ra2};

    always_comb begin
        sel = FWD_RF;
        if (tag_hit(tag_m, rax_e))
            sel = FWD_M;
        else if (tag_hit(tag_w, rax_e))
            sel = FWD_W;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the F/D/E/M/W core: forwarding, stall/flush,
// shadow tag pipeline and multi-cycle multiply sequencing.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Ra1D,
    input  logic [3:0] Ra2D,
    input  logic [3:0] WA3D,
    input  logic       RegWriteD,
    input  logic       MemtoRegD,
    input  logic       PCSrcD,
    input  logic       MulD,
    input  logic       CondPassE,
    input  logic       BranchTakenE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             valid_dec_q, valid_dec_d;
    stage_tag_t       tag_e_q, tag_e_d;
    stage_tag_t       tag_m_q, tag_m_d;
    stage_tag_t       tag_w_q, tag_w_d;
    logic [CNT_W-1:0] busy_q, busy_d;

    logic     mul_busy, ldr_stall, pc_pend;
    logic     stall_d, stall_e, flush_d, flush_e, flush_m;
    fwd_sel_t fwd_a, fwd_b;

    hz_fwd_sel u_fwd_a (
        .rax_e (tag_e_q.ra1),
        .tag_m (tag_m_q),
        .tag_w (tag_w_q),
        .sel   (fwd_a)
    );

    hz_fwd_sel u_fwd_b (
        .rax_e (tag_e_q.ra2),
        .tag_m (tag_m_q),
        .tag_w (tag_w_q),
        .sel   (fwd_b)
    );

    // While a MUL holds E, the E tag is not a load, so no load-use stall
    always_comb begin
        mul_busy  = (busy_q != '0);
        ldr_stall = tag_e_q.valid & tag_e_q.memtoreg & tag_e_q.regw
                  & ((tag_e_q.wa3 == Ra1D) | (tag_e_q.wa3 == Ra2D))
                  & valid_dec_q & ~mul_busy;
        pc_pend   = (valid_dec_q & PCSrcD) | tag_e_q.pcs | tag_m_q.pcs;
        stall_d   = ldr_stall | mul_busy;
        stall_e   = mul_busy;
        flush_d   = pc_pend | tag_w_q.pcs | BranchTakenE;
        flush_e   = ldr_stall | BranchTakenE;
        flush_m   = mul_busy;
    end

    always_comb begin
        valid_dec_d = stall_d ? valid_dec_q : ~flush_d;

        tag_e_d = tag_e_q;
        if (!stall_e) begin
            tag_e_d = BUBBLE;
            if (!flush_e && valid_dec_q) begin
                tag_e_d.valid    = 1'b1;
                tag_e_d.wa3      = WA3D;
                tag_e_d.regw     = RegWriteD;
                tag_e_d.memtoreg = MemtoRegD;
                tag_e_d.pcs      = PCSrcD;
                tag_e_d.ra1      = Ra1D;
                tag_e_d.ra2      = Ra2D;
            end
        end

        tag_m_d = BUBBLE;
        if (!flush_m) begin
            tag_m_d      = tag_e_q;
            tag_m_d.regw = tag_e_q.regw & CondPassE;
            tag_m_d.pcs  = tag_e_q.pcs & CondPassE;
        end

        tag_w_d = tag_m_q;

        busy_d = '0;
        if (mul_busy)
            busy_d = BranchTakenE ? '0 : busy_q - CNT_ONE;
        else if (valid_dec_q && MulD && !stall_e && !flush_e)
            busy_d = BUSY_LOAD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_dec_q <= 1'b0;
            tag_e_q     <= BUBBLE;
            tag_m_q     <= BUBBLE;
            tag_w_q     <= BUBBLE;
            busy_q      <= '0;
        end else begin
            valid_dec_q <= valid_dec_d;
            tag_e_q     <= tag_e_d;
            tag_m_q     <= tag_m_d;
            tag_w_q     <= tag_w_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        ForwardAE = reset ? FWD_RF : fwd_a;
        ForwardBE = reset ? FWD_RF : fwd_b;
        StallF    = ~reset & (ldr_stall | pc_pend | mul_busy);
        StallD    = ~reset & stall_d;
        StallE    = ~reset & stall_e;
        FlushD    = ~reset & flush_d;
        FlushE    = ~reset & flush_e;
        FlushM    = ~reset & flush_m;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, MUL busy,
// PC-write flushes, branch flush and reset during a multiply.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Ra1D, Ra2D, WA3D;
    logic       RegWriteD, MemtoRegD, PCSrcD, MulD;
    logic       CondPassE, BranchTakenE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [9:0] obs;

    int n_pass = 0;
    int n_chk  = 0;

    hazard_ctrl #(.MUL_LAT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .Ra1D         (Ra1D),
        .Ra2D         (Ra2D),
        .WA3D         (WA3D),
        .RegWriteD    (RegWriteD),
        .MemtoRegD    (MemtoRegD),
        .PCSrcD       (PCSrcD),
        .MulD         (MulD),
        .CondPassE    (CondPassE),
        .BranchTakenE (BranchTakenE),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushM       (FlushM)
    );

    always #5 clk = ~clk;

    // {FA, FB, StallF, StallD, StallE, FlushD, FlushE, FlushM}
    assign obs = {ForwardAE, ForwardBE, StallF, StallD, StallE,
                  FlushD, FlushE, FlushM};

    task automatic chk(input string tag, input logic [9:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // One cycle: drive just after the edge, then sit at the falling edge
    task automatic cyc(input logic rst, input logic br, input logic cp,
                       input logic [3:0] ra1, input logic [3:0] ra2,
                       input logic [3:0] wa3, input logic rw,
                       input logic mtr, input logic pcs, input logic mul);
        @(posedge clk);
        #1;
        reset        = rst;
        BranchTakenE = br;
        CondPassE    = cp;
        Ra1D         = ra1;
        Ra2D         = ra2;
        WA3D         = wa3;
        RegWriteD    = rw;
        MemtoRegD    = mtr;
        PCSrcD       = pcs;
        MulD         = mul;
        @(negedge clk);
    endtask

    task automatic nop();
        cyc(0, 0, 1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; BranchTakenE = 1'b1; CondPassE = 1'b1;
        Ra1D = 4'd1; Ra2D = 4'd1; WA3D = 4'd1;
        RegWriteD = 1'b1; MemtoRegD = 1'b1; PCSrcD = 1'b1; MulD = 1'b1;
        cyc(1, 1, 1, 4'd1, 4'd1, 4'd1, 1, 1, 1, 1);
        cyc(1, 1, 1, 4'd1, 4'd1, 4'd1, 1, 1, 1, 1);
        chk("reset_outputs", 10'b00_00_000000);
        nop();                                        // t0: D invalid
        // forwarding
        cyc(0, 0, 1, 4'd2, 4'd3, 4'd1, 1, 0, 0, 0);   // t1 ADD r1
        chk("idle_after_reset", 10'b00_00_000000);
        cyc(0, 0, 1, 4'd7, 4'd8, 4'd1, 1, 0, 0, 0);   // t2 ADD r1
        cyc(0, 0, 1, 4'd1, 4'd5, 4'd1, 1, 0, 0, 0);   // t3 SUB r1,r1,r5
        nop();                                        // t4
        chk("fwd_m_over_w", 10'b10_00_000000);
        cyc(0, 0, 1, 4'd5, 4'd1, 4'd9, 1, 0, 0, 0);   // t5 SUB r9,r5,r1
        cyc(0, 0, 1, 4'd0, 4'd0, 4'd15, 1, 0, 0, 0);  // t6 write r15
        chk("fwd_w_only", 10'b00_01_000000);
        cyc(0, 0, 1, 4'd15, 4'd15, 4'd2, 0, 0, 0, 0); // t7 read r15
        nop();                                        // t8
        chk("no_fwd_r15", 10'b00_00_000000);
        // load-use
        cyc(0, 0, 1, 4'd3, 4'd0, 4'd2, 1, 1, 0, 0);   // t9 LDR r2
        cyc(0, 0, 1, 4'd2, 4'd4, 4'd3, 1, 0, 0, 0);   // t10 ADD r3,r2,r4
        chk("ldr_stall", 10'b00_00_110010);
        cyc(0, 0, 1, 4'd2, 4'd4, 4'd3, 1, 0, 0, 0);   // t11 held
        chk("ldr_stall_one_cycle", 10'b00_00_000000);
        nop();                                        // t12
        chk("ldr_fwd_w", 10'b01_00_000000);
        // multiply
        cyc(0, 0, 1, 4'd6, 4'd7, 4'd5, 1, 0, 0, 1);   // t13 MUL r5
        chk("mul_in_d", 10'b00_00_000000);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 4'd5, 4'd1, 4'd8, 1, 0, 0, 0); // t14..16 ADD r8
            chk("mul_busy", 10'b00_00_111001);
        end
        cyc(0, 0, 1, 4'd5, 4'd1, 4'd8, 1, 0, 0, 0);   // t17
        chk("mul_release", 10'b00_00_000000);
        cyc(0, 0, 1, 4'd8, 4'd0, 4'd10, 1, 0, 0, 0);  // t18 ORR r10,r8
        chk("mul_fwd_m", 10'b10_00_000000);
        nop();                                        // t19
        chk("add_issued_once", 10'b10_00_000000);
        // PC write
        cyc(0, 0, 1, 4'd0, 4'd2, 4'd15, 1, 0, 1, 0);  // t20 MOV pc
        chk("pcw_d", 10'b00_00_100100);
        nop();
        chk("pcw_e", 10'b00_00_100100);
        nop();
        chk("pcw_m", 10'b00_00_100100);
        nop();
        chk("pcw_w", 10'b00_00_000100);
        nop();
        chk("pcw_done", 10'b00_00_000000);
        cyc(0, 0, 1, 4'd0, 4'd2, 4'd15, 1, 0, 1, 0);  // t25 MOV pc
        chk("pcw_cf_d", 10'b00_00_100100);
        cyc(0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);   // t26 cond fails
        chk("pcw_cf_e", 10'b00_00_100100);
        nop();
        chk("pcw_cf_dropped", 10'b00_00_000000);
        // branch with load-use
        cyc(0, 0, 1, 4'd1, 4'd0, 4'd4, 1, 1, 0, 0);   // t28 LDR r4
        chk("ldr_in_d", 10'b00_00_000000);
        cyc(0, 1, 1, 4'd4, 4'd4, 4'd5, 1, 0, 0, 0);   // t29 taken branch
        chk("branch_ldr", 10'b00_00_110110);
        nop();
        chk("branch_after", 10'b00_00_000000);
        // reset mid-MUL
        cyc(0, 0, 1, 4'd6, 4'd7, 4'd5, 1, 0, 0, 1);   // t31 MUL
        chk("mul2_in_d", 10'b00_00_000000);
        nop();
        chk("mul2_busy3", 10'b00_00_111001);
        cyc(1, 0, 1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);   // busy=2, reset
        chk("reset_mid_mul", 10'b00_00_000000);
        nop();
        chk("after_reset_release", 10'b00_00_000000);
        nop();
        chk("after_reset_idle", 10'b00_00_000000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
